// File: rtl/ad7276_axis_packer.sv
// Shared-timing capture engine for 1..16 dual-channel AD7276 ADCs with offset removal and
// packetised AXI-Stream output. Optional macro AD7276_TIMESTAMP_EN prepends a 32-bit timestamp beat.
module ad7276_axis_packer #(
  parameter int ADC_QTD    = 8,
  parameter int ADC_LENGTH = 12,
  parameter int SCLK_DIV   = 2,
  parameter int SAMPLE_DIV = 100,
  parameter int QUIET_CYC  = 4,
  parameter int OFFSET     = 2048
) (
  input  logic                   CLK100MHz,
  input  logic                   ARESET,
  input  logic                   enable,
  input  logic [2*ADC_QTD-1:0]   sdata,
  output logic                   cs,
  output logic                   sclk,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [15:0]            overrun_cnt,
  output logic                   busy
);

  localparam int N  = 2 * ADC_QTD;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(SCLK_DIV) + 1;
  localparam int QW = $clog2(QUIET_CYC) + 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_QUIET} state_t;

  function automatic logic signed [15:0] center_sample(input logic [ADC_LENGTH-1:0] raw);
    logic signed [ADC_LENGTH:0] diff;
    diff = $signed({1'b0, raw}) - $signed((ADC_LENGTH+1)'(OFFSET));
    return 16'(diff);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                 state, state_nxt;
  logic [TW-1:0]          timer;
  logic [DW-1:0]          div_cnt;
  logic [5:0]             edge_cnt;
  logic [QW-1:0]          quiet_cnt;
  logic                   sclk_q;
  logic                   frame_start, rise_shift, frame_done, em_free, accept, drop, last_beat;
  logic [ADC_LENGTH-1:0]  sh_p0 [N];
  logic signed [15:0]     shadow_p1 [N];
  logic [7:0]             tag_p1;
  logic [7:0]             frame_cnt;
  logic                   vld_p1;
  logic [CW-1:0]          chan_p1;
  logic [15:0]            overrun_q;
  logic [31:0]            beat_word;
`ifdef AD7276_TIMESTAMP_EN
  logic [31:0]            ts_cnt, ts_conv, ts_p1;
  logic                   ts_beat;
`endif

  assign frame_start = (state == S_IDLE) && enable && (timer == '0);
  assign frame_done  = (state == S_QUIET) && (quiet_cnt == QW'(QUIET_CYC - 1));
  // Edge counter k is odd while sclk is low; the toggle at k=5..27 is rising edge 3..14.
  assign rise_shift  = (state == S_CONVERT) && (div_cnt == DW'(SCLK_DIV - 1)) && !sclk_q &&
                       (edge_cnt >= 6'd5) && (edge_cnt <= 6'd27);
`ifdef AD7276_TIMESTAMP_EN
  assign last_beat   = vld_p1 && !ts_beat && (chan_p1 == LAST_CH);
`else
  assign last_beat   = vld_p1 && (chan_p1 == LAST_CH);
`endif
  assign em_free     = !vld_p1 || (m_axis_tready && last_beat);
  assign accept      = frame_done && em_free;
  assign drop        = frame_done && !em_free;

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET)                              timer <= '0;
    else if (!enable)                        timer <= '0;
    else if (timer == TW'(SAMPLE_DIV - 1))   timer <= '0;
    else                                     timer <= timer + 1'b1;
  end

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (frame_start) state_nxt = S_CONVERT;
      S_CONVERT: if (edge_cnt == 6'd32) state_nxt = S_QUIET;
      S_QUIET:   if (frame_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs = 1'b1;
    if (state == S_CONVERT) cs = 1'b0;
  end

  // Serial clock generation: 32 half-periods of SCLK_DIV clocks, sclk parked high afterwards.
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      div_cnt   <= '0;
      edge_cnt  <= '0;
      quiet_cnt <= '0;
      sclk_q    <= 1'b1;
    end else begin
      case (state)
        S_CONVERT: begin
          quiet_cnt <= '0;
          if (div_cnt == DW'(SCLK_DIV - 1)) begin
            div_cnt <= '0;
            if (edge_cnt != 6'd32) begin
              edge_cnt <= edge_cnt + 6'd1;
              sclk_q   <= ~sclk_q;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_QUIET: begin
          quiet_cnt <= quiet_cnt + 1'b1;
          sclk_q    <= 1'b1;
        end
        default: begin
          div_cnt   <= '0;
          edge_cnt  <= '0;
          quiet_cnt <= '0;
          sclk_q    <= 1'b1;
        end
      endcase
    end
  end

  assign sclk = sclk_q;

  // Stage p0: per-channel deserialisers
  always_ff @(posedge CLK100MHz) begin
    if (rise_shift) begin
      for (int i = 0; i < N; i++) sh_p0[i] <= {sh_p0[i][ADC_LENGTH-2:0], sdata[i]};
    end
  end

  // Stage p1: frame shadow feeding the emitter, frees p0 for the next conversion
  always_ff @(posedge CLK100MHz) begin
    if (accept) begin
      for (int i = 0; i < N; i++) shadow_p1[i] <= center_sample(sh_p0[i]);
      tag_p1 <= frame_cnt;
`ifdef AD7276_TIMESTAMP_EN
      ts_p1  <= ts_conv;
`endif
    end
  end

`ifdef AD7276_TIMESTAMP_EN
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      ts_cnt  <= '0;
      ts_conv <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (frame_start) ts_conv <= ts_cnt;
    end
  end
`endif

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      vld_p1    <= 1'b0;
      chan_p1   <= '0;
      frame_cnt <= '0;
      overrun_q <= '0;
`ifdef AD7276_TIMESTAMP_EN
      ts_beat   <= 1'b0;
`endif
    end else begin
      if (vld_p1 && m_axis_tready) begin
`ifdef AD7276_TIMESTAMP_EN
        if (ts_beat)                  ts_beat <= 1'b0;
        else if (chan_p1 == LAST_CH)  vld_p1  <= 1'b0;
        else                          chan_p1 <= chan_p1 + 1'b1;
`else
        if (chan_p1 == LAST_CH)       vld_p1  <= 1'b0;
        else                          chan_p1 <= chan_p1 + 1'b1;
`endif
      end
      // A new frame overrides the final handshake of the previous packet.
      if (accept) begin
        vld_p1    <= 1'b1;
        chan_p1   <= '0;
        frame_cnt <= frame_cnt + 8'd1;
`ifdef AD7276_TIMESTAMP_EN
        ts_beat   <= 1'b1;
`endif
      end
      if (drop) overrun_q <= sat_inc16(overrun_q);
    end
  end

  always_comb begin
    beat_word = '0;
    if (vld_p1) beat_word = {8'(chan_p1), tag_p1, shadow_p1[chan_p1]};
`ifdef AD7276_TIMESTAMP_EN
    if (vld_p1 && ts_beat) beat_word = ts_p1;
`endif
  end

  assign m_axis_tdata  = beat_word;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tlast  = last_beat;
  assign overrun_cnt   = overrun_q;
  assign busy          = (state != S_IDLE) || vld_p1;

endmodule

// File: tb/tb_ad7276_axis_packer.sv
// Directed bench for ad7276_axis_packer with a behavioural AD7276 lane model.
module tb_ad7276_axis_packer;
  localparam int ADC_QTD = 8, N = 16, ADC_LENGTH = 12, SCLK_DIV = 2;
  localparam int SAMPLE_DIV = 100, QUIET_CYC = 4, OFFSET = 2048;
`ifdef AD7276_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0, ARESET = 1'b1, enable = 1'b0, m_axis_tready = 1'b0;
  logic [N-1:0] sdata = '0;
  logic cs, sclk, m_axis_tvalid, m_axis_tlast, busy;
  logic [31:0] m_axis_tdata;
  logic [15:0] overrun_cnt;

  int errors = 0, checks = 0;
  logic [11:0] lane_val [N];
  int fall_cnt = 0;
  logic [31:0] pkt_data [40];
  logic        pkt_tl [40];
  int pkt_len, pkt_first, pkt_last_n;

  always #5 clk = ~clk;

  ad7276_axis_packer #(.ADC_QTD(ADC_QTD), .ADC_LENGTH(ADC_LENGTH), .SCLK_DIV(SCLK_DIV),
                       .SAMPLE_DIV(SAMPLE_DIV), .QUIET_CYC(QUIET_CYC), .OFFSET(OFFSET)) dut (
    .CLK100MHz(clk), .ARESET(ARESET), .enable(enable), .sdata(sdata), .cs(cs), .sclk(sclk),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overrun_cnt(overrun_cnt), .busy(busy));

  // ADC lane model: after SCLK falling edge r, present the bit sampled on rising edge r.
  always @(negedge sclk or negedge cs) begin
    int idx;
    if (sclk) fall_cnt = 0;
    else      fall_cnt = fall_cnt + 1;
    idx = 14 - fall_cnt;
    for (int i = 0; i < N; i++)
      sdata[i] = (fall_cnt >= 3 && fall_cnt <= 14) ? lane_val[i][idx] : 1'b0;
  end

  task automatic set_lanes(input logic [11:0] dflt, input int l0, input logic [11:0] v0,
                           input int l1, input logic [11:0] v1);
    for (int i = 0; i < N; i++) lane_val[i] = dflt;
    lane_val[l0] = v0;
    lane_val[l1] = v1;
  endtask

  task automatic pulse_reset();
    ARESET = 1'b1;
    @(negedge clk);
    ARESET = 1'b0;
  endtask

  task automatic collect_packet(input int budget, output bit ok);
    int n;
    n = 0; ok = 1'b0; pkt_len = 0; pkt_first = -1; pkt_last_n = -1;
    while (n < budget) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (pkt_first < 0) pkt_first = n;
        if (pkt_len < 40) begin
          pkt_data[pkt_len] = m_axis_tdata;
          pkt_tl[pkt_len]   = m_axis_tlast;
        end
        pkt_last_n = n;
        pkt_len++;
        if (m_axis_tlast) ok = 1'b1;
      end
      @(negedge clk);
      n++;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    set_lanes(12'h800, 0, 12'h800, 1, 12'h800);
    ARESET = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", sclk); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (overrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_overrun got %h want 0", overrun_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    ARESET = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [39:0] lm, lm_exp;
    logic [31:0] exp;
    int bad;
    set_lanes(12'h800, 0, 12'hABC, 1, 12'h800);
    pulse_reset();
    collect_packet(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done got no tlast want tlast within 300 cycles"); end
    checks++; if (pkt_len != N + HDR) begin errors++; $display("FAIL basic_len got %0d want %0d", pkt_len, N + HDR); end
    checks++; if (pkt_first != 70) begin errors++; $display("FAIL basic_latency got %0d want 70", pkt_first); end
    checks++; if (pkt_last_n - pkt_first + 1 != N + HDR) begin errors++; $display("FAIL basic_span got %0d want %0d", pkt_last_n - pkt_first + 1, N + HDR); end
    checks++; if (pkt_data[HDR] !== 32'h000002BC) begin errors++; $display("FAIL basic_beat0 got %h want 000002bc", pkt_data[HDR]); end
    bad = 0;
    for (int i = 1; i < N; i++) begin
      exp = {8'(i), 8'h00, 16'h0000};
      if (pkt_data[HDR+i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_mid_beats got %0d wrong beats want 0", bad); end
    lm = '0;
    for (int i = 0; i < pkt_len && i < 40; i++) lm[i] = pkt_tl[i];
    lm_exp = '0; lm_exp[N+HDR-1] = 1'b1;
    checks++; if (lm !== lm_exp) begin errors++; $display("FAIL basic_tlast got %h want %h", lm, lm_exp); end
  endtask

  task automatic test_extremes_frames();
    bit ok;
    int bad;
    logic [7:0] fc255, fc256;
    set_lanes(12'h800, 2, 12'h000, 3, 12'hFFF);
    pulse_reset();
    collect_packet(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ext_done got no tlast want tlast"); end
    checks++; if (pkt_data[HDR+2] !== 32'h0200F800) begin errors++; $display("FAIL ext_raw000 got %h want 0200f800", pkt_data[HDR+2]); end
    checks++; if (pkt_data[HDR+3] !== 32'h030007FF) begin errors++; $display("FAIL ext_rawfff got %h want 030007ff", pkt_data[HDR+3]); end
    checks++; if (pkt_data[HDR] !== 32'h00000000) begin errors++; $display("FAIL ext_beat0 got %h want 00000000", pkt_data[HDR]); end
    bad = 0; fc255 = '0; fc256 = '1;
    for (int f = 1; f <= 256; f++) begin
      collect_packet(200, ok);
      if (!ok || pkt_data[HDR][23:16] !== 8'(f)) bad++;
      if (f == 255) fc255 = pkt_data[HDR][23:16];
      if (f == 256) fc256 = pkt_data[HDR][23:16];
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame_seq got %0d bad packets want 0", bad); end
    checks++; if (fc255 !== 8'hFF) begin errors++; $display("FAIL frame_255 got %h want ff", fc255); end
    checks++; if (fc256 !== 8'h00) begin errors++; $display("FAIL frame_wrap got %h want 00", fc256); end
    checks++; if (pkt_data[HDR+3] !== 32'h030007FF) begin errors++; $display("FAIL ext_after_wrap got %h want 030007ff", pkt_data[HDR+3]); end
  endtask

  task automatic test_cs_sclk();
    int n, t, h, bad, rises, idle_bad;
    logic prev, exp_s;
    pulse_reset();
    n = 0;
    while (cs && n < 200) begin @(negedge clk); n++; end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL cs_fall got cs=%b want 0 within 200 cycles", cs); end
    t = 0; bad = 0; rises = 0; prev = 1'b1;
    while (!cs && t < 200) begin
      exp_s = ((t / SCLK_DIV) % 2 == 0) ? 1'b1 : 1'b0;
      if (sclk !== exp_s) bad++;
      if (sclk && !prev) rises++;
      prev = sclk;
      @(negedge clk); t++;
    end
    checks++; if (t != 65) begin errors++; $display("FAIL cs_low_len got %0d want 65", t); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sclk_pattern got %0d wrong cycles want 0", bad); end
    checks++; if (rises != 16) begin errors++; $display("FAIL sclk_rises got %0d want 16", rises); end
    h = 0; idle_bad = 0;
    while (cs && h < 400) begin
      if (!sclk) idle_bad++;
      @(negedge clk); h++;
    end
    checks++; if (h != SAMPLE_DIV - 65) begin errors++; $display("FAIL cs_high_len got %0d want %0d", h, SAMPLE_DIV - 65); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL sclk_idle got %0d low cycles want 0", idle_bad); end
  endtask

  task automatic test_stall();
    bit ok;
    int n, bad;
    logic [31:0] first;
    logic first_last;
    set_lanes(12'h800, 0, 12'hABC, 1, 12'h800);
    m_axis_tready = 1'b0;
    pulse_reset();
    n = 0;
    while (!m_axis_tvalid && n < 300) begin @(negedge clk); n++; end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", m_axis_tvalid); end
    first = m_axis_tdata; first_last = m_axis_tlast; bad = 0;
    repeat (3 * SAMPLE_DIV + 10) begin
      @(negedge clk);
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== first || m_axis_tlast !== first_last) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad); end
    checks++; if (overrun_cnt !== 16'd3) begin errors++; $display("FAIL stall_overrun got %0d want 3", overrun_cnt); end
    m_axis_tready = 1'b1;
    collect_packet(100, ok);
    checks++; if (!ok || pkt_len != N + HDR) begin errors++; $display("FAIL stall_drain_len got %0d want %0d", pkt_len, N + HDR); end
    checks++; if (pkt_data[0] !== first) begin errors++; $display("FAIL stall_drain_first got %h want %h", pkt_data[0], first); end
    checks++; if (pkt_data[HDR] !== 32'h000002BC) begin errors++; $display("FAIL stall_drain_beat0 got %h want 000002bc", pkt_data[HDR]); end
    checks++; if (pkt_data[HDR+15] !== 32'h0F000000) begin errors++; $display("FAIL stall_drain_beat15 got %h want 0f000000", pkt_data[HDR+15]); end
    collect_packet(200, ok);
    checks++; if (!ok || pkt_data[HDR][23:16] !== 8'd1) begin errors++; $display("FAIL stall_next_frame got %h want 01", pkt_data[HDR][23:16]); end
    checks++; if (overrun_cnt !== 16'd3) begin errors++; $display("FAIL stall_overrun_hold got %0d want 3", overrun_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    set_lanes(12'h800, 0, 12'hABC, 1, 12'h800);
    m_axis_tready = 1'b1;
    pulse_reset();
    n = 0;
    while (cs && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midconv_pre_sclk got %b want 0", sclk); end
    ARESET = 1'b1; #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL midconv_cs got %b want 1", cs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL midconv_sclk got %b want 1", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midconv_busy got %b want 0", busy); end
    @(negedge clk); ARESET = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    ARESET = 1'b1; #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midpkt_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin errors++; $display("FAIL midpkt_data got %b/%h want 0/00000000", m_axis_tlast, m_axis_tdata); end
    @(negedge clk); ARESET = 1'b0;
    collect_packet(300, ok);
    checks++; if (!ok || pkt_len != N + HDR) begin errors++; $display("FAIL midpkt_next_len got %0d want %0d", pkt_len, N + HDR); end
    checks++; if (pkt_data[HDR] !== 32'h000002BC) begin errors++; $display("FAIL midpkt_next_beat0 got %h want 000002bc", pkt_data[HDR]); end
  endtask

`ifdef AD7276_TIMESTAMP_EN
  task automatic test_timestamp();
    bit ok;
    logic [31:0] t0, t1;
    set_lanes(12'h800, 0, 12'hABC, 1, 12'h800);
    m_axis_tready = 1'b1;
    pulse_reset();
    collect_packet(300, ok);
    t0 = pkt_data[0];
    checks++; if (!ok || pkt_tl[N] !== 1'b1 || pkt_tl[0] !== 1'b0) begin errors++; $display("FAIL ts_tlast got %b/%b want 0/1", pkt_tl[0], pkt_tl[N]); end
    collect_packet(200, ok);
    t1 = pkt_data[0];
    checks++; if (t1 - t0 != 32'(SAMPLE_DIV)) begin errors++; $display("FAIL ts_delta got %0d want %0d", t1 - t0, SAMPLE_DIV); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes_frames();
    test_cs_sclk();
    test_stall();
    test_reset_mid();
`ifdef AD7276_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
